// File: rtl/pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_pkg                                                             |
// | Shared types and default sizes for the pooling sequencer.            |
// |   pool_state_t : controller sequencing states                        |
// |   POOL_WIN     : default window elements per channel                 |
// |   POOL_DW      : default element / result width                      |
// |   pool_win_t   : one full window at the default sizes                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pool_pkg;

  localparam int POOL_WIN = 64;
  localparam int POOL_DW  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } pool_state_t;

  typedef logic [POOL_WIN-1:0][POOL_DW-1:0] pool_win_t;

endpackage
`default_nettype wire

// File: rtl/pool_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_ctrl_if                                                         |
// | Command, window and result signals around pool_ctrl.                 |
// |   command : start, num_ch, busy, done                                |
// |   window  : fm_valid, fm_ready, fm_in, fm_win                        |
// |   datapath: pool_en, pool_res                                        |
// |   result  : res_valid, res_ready, res_data, res_idx                  |
// |   modport slave  : the controller side                               |
// |   modport master : the surrounding system side                       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface pool_ctrl_if import pool_pkg::*; #(
  parameter int WIN  = POOL_WIN,
  parameter int DW   = POOL_DW,
  parameter int CH_W = 8
);

  logic                    start;
  logic [CH_W-1:0]         num_ch;
  logic                    busy;
  logic                    done;
  logic                    fm_valid;
  logic                    fm_ready;
  logic [WIN-1:0][DW-1:0]  fm_in;
  logic [WIN-1:0][DW-1:0]  fm_win;
  logic                    pool_en;
  logic [DW-1:0]           pool_res;
  logic                    res_valid;
  logic                    res_ready;
  logic [DW-1:0]           res_data;
  logic [CH_W-1:0]         res_idx;

  modport slave (
    input  start, num_ch, fm_valid, fm_in, pool_res, res_ready,
    output busy, done, fm_ready, fm_win, pool_en, res_valid, res_data, res_idx
  );

  modport master (
    output start, num_ch, fm_valid, fm_in, pool_res, res_ready,
    input  busy, done, fm_ready, fm_win, pool_en, res_valid, res_data, res_idx
  );

endinterface
`default_nettype wire

// File: rtl/pool_win_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_win_reg                                                         |
// | Window register: captures din in reversed element order on load,     |
// | otherwise holds. Synchronous active-low clear.                       |
// |   clk, rst : clock, synchronous active-low reset                     |
// |   load     : capture enable                                          |
// |   din      : incoming window, elements 0..WIN-1                      |
// |   dout     : registered window, dout[j] = din[WIN-1-j]               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pool_win_reg import pool_pkg::*; #(
  parameter int WIN = POOL_WIN,
  parameter int DW  = POOL_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [WIN-1:0][DW-1:0] din,
  output logic [WIN-1:0][DW-1:0] dout
);

  logic [WIN-1:0][DW-1:0] win_q;
  logic [WIN-1:0][DW-1:0] win_d;
  logic [WIN-1:0][DW-1:0] din_rev;

  for (genvar j = 0; j < WIN; j++) begin : g_rev
    assign din_rev[j] = din[WIN-1-j];
  end

  always_comb begin
    win_d = win_q;
    if (load) begin
      win_d = din_rev;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign dout = win_q;

endmodule
`default_nettype wire

// File: rtl/pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pool_ctrl                                                            |
// | Sequences a pooling run: per channel it takes one window, enables    |
// | the pool datapath for LAT cycles and returns one result.             |
// |   clk, rst : clock, synchronous active-low reset                     |
// |   bus      : pool_ctrl_if.slave (command, window, datapath, result)  |
// | Build option: POOL_CTRL_RELU_EN clamps negative results to zero.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pool_ctrl import pool_pkg::*; #(
  parameter int WIN  = POOL_WIN,
  parameter int DW   = POOL_DW,
  parameter int LAT  = 6,
  parameter int CH_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  pool_ctrl_if.slave  bus
);

  localparam int LAT_W = $clog2(LAT + 1);

  pool_state_t      state_q,    state_d;
  logic [CH_W-1:0]  num_ch_q,   num_ch_d;
  logic [CH_W-1:0]  ch_cnt_q,   ch_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q,  lat_cnt_d;
  logic [DW-1:0]    res_data_q, res_data_d;
  logic [CH_W-1:0]  res_idx_q,  res_idx_d;
  logic             done_q,     done_d;
  logic             win_load;
  logic [DW-1:0]    res_val;

`ifdef POOL_CTRL_RELU_EN
  assign res_val = bus.pool_res[DW-1] ? '0 : bus.pool_res;
`else
  assign res_val = bus.pool_res;
`endif

  always_comb begin
    state_d    = state_q;
    num_ch_d   = num_ch_q;
    ch_cnt_d   = ch_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    done_d     = 1'b0;
    win_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.num_ch != '0) begin
            num_ch_d = bus.num_ch;
            ch_cnt_d = '0;
            state_d  = LOAD;
          end else begin
            // An empty run completes immediately without leaving IDLE.
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.fm_valid) begin
          win_load  = 1'b1;
          lat_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        lat_cnt_d = lat_cnt_q + LAT_W'(1);
        // pool_res is taken during the last enabled datapath cycle.
        if (lat_cnt_q == LAT_W'(LAT - 1)) begin
          res_data_d = res_val;
          res_idx_d  = ch_cnt_q;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (bus.res_ready) begin
          // Compare against num_ch-1 so a full-scale count never wraps ch_cnt.
          if (ch_cnt_q == num_ch_q - CH_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
            state_d  = LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      num_ch_q   <= '0;
      ch_cnt_q   <= '0;
      lat_cnt_q  <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_ch_q   <= num_ch_d;
      ch_cnt_q   <= ch_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
      done_q     <= done_d;
    end
  end

  pool_win_reg #(
    .WIN (WIN),
    .DW  (DW)
  ) u_win_reg (
    .clk  (clk),
    .rst  (rst),
    .load (win_load),
    .din  (bus.fm_in),
    .dout (bus.fm_win)
  );

  assign bus.busy      = (state_q != IDLE);
  assign bus.fm_ready  = (state_q == LOAD);
  assign bus.pool_en   = (state_q == RUN);
  assign bus.res_valid = (state_q == OUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pool_ctrl                                                         |
// | Self-checking bench for pool_ctrl: a timeline model predicts every   |
// | output each cycle; directed runs pin the model with literal values.  |
// | Honours POOL_CTRL_RELU_EN in its expectations.                       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pool_ctrl;
  import pool_pkg::*;

  localparam int WIN  = POOL_WIN;
  localparam int DW   = POOL_DW;
  localparam int LAT  = 6;
  localparam int CH_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pool_ctrl_if #(.WIN(WIN), .DW(DW), .CH_W(CH_W)) bus ();

  pool_ctrl #(.WIN(WIN), .DW(DW), .LAT(LAT), .CH_W(CH_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef POOL_CTRL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Timeline model: tracks where the run is in terms of "waiting for a
  // window" and "cycles elapsed since the window was taken".
  bit              m_active = 0;
  bit              m_wait   = 0;
  int              m_k      = 0;
  int              m_n      = 0;
  int              m_ch     = 0;
  bit              m_done   = 0;
  logic [DW-1:0]   m_rdata  = '0;
  logic [CH_W-1:0] m_ridx   = '0;
  pool_win_t       m_win    = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_active <= 0; m_wait <= 0; m_k <= 0; m_n <= 0; m_ch <= 0;
      m_done <= 0; m_rdata <= '0; m_ridx <= '0; m_win <= '0;
    end else begin
      m_done <= 0;
      if (!m_active) begin
        if (bus.start) begin
          if (bus.num_ch != 0) begin
            m_active <= 1; m_wait <= 1; m_n <= int'(bus.num_ch); m_ch <= 0;
          end else begin
            m_done <= 1;
          end
        end
      end else if (m_wait) begin
        if (bus.fm_valid) begin
          for (int j = 0; j < WIN; j++) m_win[j] <= bus.fm_in[WIN-1-j];
          m_wait <= 0;
          m_k    <= 1;
        end
      end else if (m_k <= LAT) begin
        if (m_k == LAT) begin
          m_rdata <= relu(bus.pool_res);
          m_ridx  <= CH_W'(m_ch);
        end
        m_k <= m_k + 1;
      end else if (bus.res_ready) begin
        if (m_ch == m_n - 1) begin
          m_active <= 0; m_done <= 1;
        end else begin
          m_ch <= m_ch + 1; m_wait <= 1;
        end
      end
    end
  end

  // Observation counters used by the directed runs.
  int              hs_cnt = 0, done_cnt = 0, pen_cnt = 0, busy_seen = 0, fmr_seen = 0;
  logic [CH_W-1:0] idx_q[$];
  logic [DW-1:0]   data_q[$];

  task automatic clear_obs();
    hs_cnt = 0; done_cnt = 0; pen_cnt = 0; busy_seen = 0; fmr_seen = 0;
    idx_q.delete(); data_q.delete();
  endtask

  // Compare process: every cycle, mid-cycle, all outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("busy",      64'(bus.busy),      64'(m_active));
    chk("fm_ready",  64'(bus.fm_ready),  64'(m_active && m_wait));
    chk("pool_en",   64'(bus.pool_en),   64'(m_active && !m_wait && m_k >= 1 && m_k <= LAT));
    chk("res_valid", 64'(bus.res_valid), 64'(m_active && !m_wait && m_k > LAT));
    chk("done",      64'(bus.done),      64'(m_done));
    chk("res_data",  64'(bus.res_data),  64'(m_rdata));
    chk("res_idx",   64'(bus.res_idx),   64'(m_ridx));
    n_checks++;
    if (bus.fm_win === m_win) n_pass++;
    else begin
      for (int j = 0; j < WIN; j++) begin
        if (bus.fm_win[j] !== m_win[j]) begin
          $display("FAIL fm_win: element %0d got 0x%0h, want 0x%0h", j, bus.fm_win[j], m_win[j]);
          break;
        end
      end
    end
    if (bus.res_valid && bus.res_ready) begin
      hs_cnt++; idx_q.push_back(bus.res_idx); data_q.push_back(bus.res_data);
    end
    if (bus.done)     done_cnt++;
    if (bus.pool_en)  pen_cnt++;
    if (bus.busy)     busy_seen++;
    if (bus.fm_ready) fmr_seen++;
  end

  // Input driver: random handshakes and data, or fixed always-ready mode.
  bit fixed_mode = 0;
  int p_valid = 100, p_ready = 100;
  int stall_idx = -1, stall_left = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (fixed_mode) begin
      bus.fm_valid  = 1'b1;
      bus.res_ready = 1'b1;
    end else begin
      bus.fm_valid  = ($urandom_range(99) < p_valid);
      bus.res_ready = ($urandom_range(99) < p_ready);
      bus.pool_res  = DW'($urandom);
      for (int j = 0; j < WIN; j++) bus.fm_in[j] = DW'($urandom);
    end
    if (stall_left > 0 && bus.res_valid && int'(bus.res_idx) == stall_idx) begin
      bus.res_ready = 1'b0;
      stall_left--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n);
    clear_obs();
    bus.start  = 1'b1;
    bus.num_ch = CH_W'(n);
    step();
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int limit, output int cyc);
    cyc = 0;
    while (done_cnt == 0 && cyc < limit) begin
      step();
      cyc++;
    end
    chk({nm, "_finished"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_pool_en(input string nm, input int need_hs, input int limit);
    int c = 0;
    while (!(bus.pool_en && hs_cnt >= need_hs) && c < limit) begin
      step();
      c++;
    end
    chk({nm, "_reached_run"}, 64'(c < limit), 64'd1);
  endtask

  function automatic logic [63:0] q_idx(input int i);
    return (idx_q.size() > i) ? 64'(idx_q[i]) : 64'hDEAD;
  endfunction

  function automatic logic [63:0] q_data(input int i);
    return (data_q.size() > i) ? 64'(data_q[i]) : 64'hDEAD;
  endfunction

  int cyc;
  logic [DW-1:0] exp_neg;

  initial begin
    bus.start = 0; bus.num_ch = '0; bus.fm_valid = 0; bus.res_ready = 0;
    bus.pool_res = '0; bus.fm_in = '0;
    repeat (3) step();
    chk("reset_busy",     64'(bus.busy), 64'd0);
    chk("reset_res_data", 64'(bus.res_data), 64'd0);
    rst = 1'b1;
    step();

    // Single channel, ramp window, fixed result.
    fixed_mode = 1;
    for (int j = 0; j < WIN; j++) bus.fm_in[j] = DW'(j);
    bus.pool_res = 16'h0042;
    step();
    launch(1);
    wait_done("t1", 50, cyc);
    step();
    chk("t1_win0",    64'(bus.fm_win[0]),  64'd63);
    chk("t1_win63",   64'(bus.fm_win[63]), 64'd0);
    chk("t1_pool_en", 64'(pen_cnt),  64'd6);
    chk("t1_results", 64'(hs_cnt),   64'd1);
    chk("t1_data",    q_data(0),     64'h0042);
    chk("t1_idx",     q_idx(0),      64'd0);
    chk("t1_done",    64'(done_cnt), 64'd1);

    // Three channels, result stalled five cycles on channel 1.
    fixed_mode = 0; p_valid = 100; p_ready = 100;
    stall_idx = 1; stall_left = 5;
    launch(3);
    wait_done("t2", 200, cyc);
    step();
    chk("t2_results", 64'(hs_cnt), 64'd3);
    chk("t2_idx0", q_idx(0), 64'd0);
    chk("t2_idx1", q_idx(1), 64'd1);
    chk("t2_idx2", q_idx(2), 64'd2);
    chk("t2_pool_en", 64'(pen_cnt), 64'(3 * LAT));
    chk("t2_stall_used", 64'(stall_left), 64'd0);
    chk("t2_done", 64'(done_cnt), 64'd1);
    stall_idx = -1;

    // Empty run.
    launch(0);
    wait_done("t3", 10, cyc);
    repeat (3) step();
    chk("t3_latency",  64'(cyc), 64'd1);
    chk("t3_done",     64'(done_cnt), 64'd1);
    chk("t3_busy",     64'(busy_seen), 64'd0);
    chk("t3_fm_ready", 64'(fmr_seen), 64'd0);

    // Reset during RUN of the second of four channels.
    launch(4);
    wait_pool_en("t4", 1, 200);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t4_busy",      64'(bus.busy), 64'd0);
    chk("t4_pool_en",   64'(bus.pool_en), 64'd0);
    chk("t4_res_valid", 64'(bus.res_valid), 64'd0);
    chk("t4_fm_ready",  64'(bus.fm_ready), 64'd0);
    chk("t4_res_data",  64'(bus.res_data), 64'd0);
    chk("t4_res_idx",   64'(bus.res_idx), 64'd0);
    chk("t4_fm_win",    64'(bus.fm_win != '0), 64'd0);
    step();
    launch(2);
    wait_done("t4b", 200, cyc);
    step();
    chk("t4_restart_idx0", q_idx(0), 64'd0);
    chk("t4_restart_idx1", q_idx(1), 64'd1);

    // start re-asserted mid-run is ignored.
    launch(2);
    wait_pool_en("t5", 0, 200);
    bus.start = 1'b1; bus.num_ch = 8'd9;
    step();
    bus.start = 1'b0;
    wait_done("t5", 200, cyc);
    repeat (3) step();
    chk("t5_results", 64'(hs_cnt), 64'd2);
    chk("t5_done", 64'(done_cnt), 64'd1);

    // Negative result through the optional clamp.
    fixed_mode = 1;
    bus.pool_res = 16'hFF80;
    step();
    launch(1);
    wait_done("t6", 50, cyc);
`ifdef POOL_CTRL_RELU_EN
    exp_neg = 16'h0000;
`else
    exp_neg = 16'hFF80;
`endif
    chk("t6_data", q_data(0), 64'(exp_neg));

    // Full-scale channel count completes without wrapping.
    fixed_mode = 0; p_valid = 100; p_ready = 100;
    launch(255);
    wait_done("t7", 255 * (LAT + 4) + 50, cyc);
    step();
    chk("t7_results", 64'(hs_cnt), 64'd255);
    chk("t7_last_idx", q_idx(254), 64'd254);
    chk("t7_done", 64'(done_cnt), 64'd1);

    // Randomised runs checked cycle by cycle against the model.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = $urandom_range(6, 1);
      p_valid = $urandom_range(100, 30);
      p_ready = $urandom_range(100, 30);
      repeat ($urandom_range(3)) step();
      launch(n);
      wait_done("rand", 1000, cyc);
      step();
      chk("rand_results", 64'(hs_cnt), 64'(n));
    end

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
